// File: rtl/mc_ctrl.sv
// Multi-cycle control sequencer for the MIPS-subset datapath with a ready/timeout memory handshake.
// Optional feature: define MC_CTRL_JUMP_EN to decode opcode 0x02 into the JUMP state.
module mc_ctrl #(
  parameter int WAIT_MAX = 15
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [5:0] opcode_i,
  input  logic       zero_i,
  input  logic       mem_ready_i,
  output logic       pc_en_o,
  output logic       iord_o,
  output logic       mem_read_o,
  output logic       mem_write_o,
  output logic       ir_write_o,
  output logic       memtoreg_o,
  output logic       reg_dst_o,
  output logic       reg_write_o,
  output logic       alu_src_a_o,
  output logic [1:0] alu_src_b_o,
  output logic [2:0] alu_op_o,
  output logic       zext_o,
  output logic [1:0] pc_src_o,
  output logic [3:0] state_o,
  output logic       err_o
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXEC_R    = 4'd6,
    S_ALU_WB    = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_EXEC_I    = 4'd10,
    S_I_WB      = 4'd11
  } state_e;

  localparam logic [7:0] WAIT_LAST = 8'(WAIT_MAX - 1);

  state_e     state_q, state_d;
  logic [7:0] wcnt_q, wcnt_d;
  logic [5:0] opc_q, opc_d;
  logic       rdy, req, tmo;

  // Ready is masked during reset so the held FETCH state cannot raise any write enable.
  always_comb begin
    rdy = mem_ready_i & rst_i;
    req = (state_q == S_FETCH) || (state_q == S_MEM_READ) || (state_q == S_MEM_WRITE);
    tmo = req && rst_i && !rdy && (wcnt_q == WAIT_LAST);
    wcnt_d = (req && !rdy && !tmo) ? wcnt_q + 8'd1 : 8'd0;
  end

  always_comb begin
    state_d     = state_q;
    opc_d       = opc_q;
    pc_en_o     = 1'b0;
    iord_o      = 1'b0;
    mem_read_o  = 1'b0;
    mem_write_o = 1'b0;
    ir_write_o  = 1'b0;
    memtoreg_o  = 1'b0;
    reg_dst_o   = 1'b0;
    reg_write_o = 1'b0;
    alu_src_a_o = 1'b0;
    alu_src_b_o = 2'b00;
    alu_op_o    = 3'b000;
    zext_o      = 1'b0;
    pc_src_o    = 2'b00;
    err_o       = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_read_o  = 1'b1;
        alu_src_b_o = 2'b01;
        if (rdy) begin
          ir_write_o = 1'b1;
          pc_en_o    = 1'b1;
          state_d    = S_DECODE;
        end else if (tmo) begin
          err_o = 1'b1;
        end
      end
      S_DECODE: begin
        alu_src_b_o = 2'b11;
        opc_d       = opcode_i;
        case (opcode_i)
          6'h00:               state_d = S_EXEC_R;
          6'h23, 6'h2B:        state_d = S_MEM_ADDR;
          6'h04, 6'h05:        state_d = S_BRANCH;
          6'h08, 6'h0A, 6'h0D: state_d = S_EXEC_I;
`ifdef MC_CTRL_JUMP_EN
          6'h02:               state_d = S_JUMP;
`endif
          default: begin
            err_o   = 1'b1;
            state_d = S_FETCH;
          end
        endcase
      end
      S_MEM_ADDR: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = 2'b10;
        state_d     = (opc_q == 6'h2B) ? S_MEM_WRITE : S_MEM_READ;
      end
      S_MEM_READ: begin
        mem_read_o = 1'b1;
        iord_o     = 1'b1;
        if (rdy)      state_d = S_MEM_WB;
        else if (tmo) begin
          err_o   = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_MEM_WB: begin
        reg_write_o = 1'b1;
        memtoreg_o  = 1'b1;
        state_d     = S_FETCH;
      end
      S_MEM_WRITE: begin
        mem_write_o = 1'b1;
        iord_o      = 1'b1;
        if (rdy)      state_d = S_FETCH;
        else if (tmo) begin
          err_o   = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_EXEC_R: begin
        alu_src_a_o = 1'b1;
        alu_op_o    = 3'b010;
        state_d     = S_ALU_WB;
      end
      S_ALU_WB: begin
        reg_write_o = 1'b1;
        reg_dst_o   = 1'b1;
        state_d     = S_FETCH;
      end
      S_EXEC_I: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = 2'b10;
        case (opc_q)
          6'h0A:   alu_op_o = 3'b011;
          6'h0D: begin
            alu_op_o = 3'b100;
            zext_o   = 1'b1;
          end
          default: alu_op_o = 3'b000;
        endcase
        state_d = S_I_WB;
      end
      S_I_WB: begin
        reg_write_o = 1'b1;
        state_d     = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a_o = 1'b1;
        alu_op_o    = 3'b001;
        pc_src_o    = 2'b01;
        pc_en_o     = (opc_q == 6'h05) ? !zero_i : zero_i;
        state_d     = S_FETCH;
      end
`ifdef MC_CTRL_JUMP_EN
      S_JUMP: begin
        pc_src_o = 2'b10;
        pc_en_o  = 1'b1;
        state_d  = S_FETCH;
      end
`endif
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= S_FETCH;
      wcnt_q  <= 8'd0;
      opc_q   <= 6'd0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      opc_q   <= opc_d;
    end
  end

  assign state_o = state_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Table-driven, scoreboarded bench for mc_ctrl (instantiated with WAIT_MAX = 4).
module tb_mc_ctrl;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic [5:0] opcode_i;
  logic       zero_i;
  logic       mem_ready_i;
  logic       pc_en_o, iord_o, mem_read_o, mem_write_o, ir_write_o;
  logic       memtoreg_o, reg_dst_o, reg_write_o, alu_src_a_o, zext_o, err_o;
  logic [1:0] alu_src_b_o, pc_src_o;
  logic [2:0] alu_op_o;
  logic [3:0] state_o;

  mc_ctrl #(.WAIT_MAX(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .opcode_i(opcode_i), .zero_i(zero_i),
    .mem_ready_i(mem_ready_i), .pc_en_o(pc_en_o), .iord_o(iord_o),
    .mem_read_o(mem_read_o), .mem_write_o(mem_write_o), .ir_write_o(ir_write_o),
    .memtoreg_o(memtoreg_o), .reg_dst_o(reg_dst_o), .reg_write_o(reg_write_o),
    .alu_src_a_o(alu_src_a_o), .alu_src_b_o(alu_src_b_o), .alu_op_o(alu_op_o),
    .zext_o(zext_o), .pc_src_o(pc_src_o), .state_o(state_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [5:0] opc;
    logic [5:0] ctx;
    logic       zero;
    logic       rdy;
    logic [3:0] st;
    logic       pcen;
    logic       irw;
    logic       err;
  } vec_t;

  vec_t         vecs[$];
  logic [21:0]  sb[$];
  int           checks = 0;
  int           errors = 0;

  function automatic logic [21:0] actual();
    return {state_o, pc_en_o, iord_o, mem_read_o, mem_write_o, ir_write_o, memtoreg_o,
            reg_dst_o, reg_write_o, alu_src_a_o, alu_src_b_o, alu_op_o, zext_o, pc_src_o, err_o};
  endfunction

  // Expected outputs for a state from the per-state output table; dynamic bits overridden.
  function automatic logic [21:0] expect_out(logic [3:0] st, logic [5:0] ctx,
                                             logic pcen, logic irw, logic err);
    logic iord, mrd, mwr, m2r, rdst, rwr, asa, zext;
    logic [1:0] asb, psrc;
    logic [2:0] aop;
    {iord, mrd, mwr, m2r, rdst, rwr, asa, zext} = '0;
    asb = 2'b00; psrc = 2'b00; aop = 3'b000;
    case (st)
      4'd0:  begin mrd = 1; asb = 2'b01; end
      4'd1:  asb = 2'b11;
      4'd2:  begin asa = 1; asb = 2'b10; end
      4'd3:  begin mrd = 1; iord = 1; end
      4'd4:  begin rwr = 1; m2r = 1; end
      4'd5:  begin mwr = 1; iord = 1; end
      4'd6:  begin asa = 1; aop = 3'b010; end
      4'd7:  begin rwr = 1; rdst = 1; end
      4'd8:  begin asa = 1; aop = 3'b001; psrc = 2'b01; end
      4'd9:  psrc = 2'b10;
      4'd10: begin
        asa = 1; asb = 2'b10;
        if (ctx == 6'h0A) aop = 3'b011;
        else if (ctx == 6'h0D) begin aop = 3'b100; zext = 1; end
      end
      4'd11: rwr = 1;
      default: ;
    endcase
    return {st, pcen, iord, mrd, mwr, irw, m2r, rdst, rwr, asa, asb, aop, zext, psrc, err};
  endfunction

  function automatic void add(logic [5:0] opc, logic [5:0] ctx, logic zero, logic rdy,
                              logic [3:0] st, logic pcen, logic irw, logic err);
    vec_t v;
    v.opc = opc; v.ctx = ctx; v.zero = zero; v.rdy = rdy;
    v.st = st; v.pcen = pcen; v.irw = irw; v.err = err;
    vecs.push_back(v);
  endfunction

  task automatic compare(string name, logic [21:0] act, logic [21:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic step(vec_t v, int idx);
    logic [21:0] e;
    @(negedge clk_i);
    opcode_i    = v.opc;
    zero_i      = v.zero;
    mem_ready_i = v.rdy;
    sb.push_back(expect_out(v.st, v.ctx, v.pcen, v.irw, v.err));
    #2;
    if (sb.size() == 0) begin
      checks++; errors++;
      $display("FAIL vec%0d: scoreboard empty", idx);
    end else begin
      e = sb.pop_front();
      compare($sformatf("vec%0d", idx), actual(), e);
    end
  endtask

  initial begin
    rst_i = 1'b0; opcode_i = 6'h00; zero_i = 1'b0; mem_ready_i = 1'b1;
    #2;
    compare("reset_init", actual(), expect_out(4'd0, 6'h00, 1'b0, 1'b0, 1'b0));

    // R-type then lw, zero wait
    add(6'h00,6'h00,0,1, 0,1,1,0); add(6'h00,6'h00,0,1, 1,0,0,0);
    add(6'h00,6'h00,0,0, 6,0,0,0); add(6'h00,6'h00,0,1, 7,0,0,0);
    add(6'h23,6'h23,0,1, 0,1,1,0); add(6'h23,6'h23,0,1, 1,0,0,0);
    add(6'h23,6'h23,0,0, 2,0,0,0); add(6'h23,6'h23,0,1, 3,0,0,0);
    add(6'h23,6'h23,0,1, 4,0,0,0);
    // sw
    add(6'h2B,6'h2B,0,1, 0,1,1,0); add(6'h2B,6'h2B,0,1, 1,0,0,0);
    add(6'h2B,6'h2B,0,1, 2,0,0,0); add(6'h2B,6'h2B,0,1, 5,0,0,0);
    // beq/bne with both zero values
    add(6'h04,6'h04,1,1, 0,1,1,0); add(6'h04,6'h04,1,1, 1,0,0,0); add(6'h04,6'h04,1,1, 8,1,0,0);
    add(6'h05,6'h05,1,1, 0,1,1,0); add(6'h05,6'h05,1,1, 1,0,0,0); add(6'h05,6'h05,1,1, 8,0,0,0);
    add(6'h04,6'h04,0,1, 0,1,1,0); add(6'h04,6'h04,0,1, 1,0,0,0); add(6'h04,6'h04,0,1, 8,0,0,0);
    add(6'h05,6'h05,0,1, 0,1,1,0); add(6'h05,6'h05,0,1, 1,0,0,0); add(6'h05,6'h05,0,1, 8,1,0,0);
    // addi, slti, ori
    add(6'h08,6'h08,0,1, 0,1,1,0); add(6'h08,6'h08,0,1, 1,0,0,0);
    add(6'h08,6'h08,0,1, 10,0,0,0); add(6'h08,6'h08,0,1, 11,0,0,0);
    add(6'h0A,6'h0A,0,1, 0,1,1,0); add(6'h0A,6'h0A,0,1, 1,0,0,0);
    add(6'h0A,6'h0A,0,1, 10,0,0,0); add(6'h0A,6'h0A,0,1, 11,0,0,0);
    add(6'h0D,6'h0D,0,1, 0,1,1,0); add(6'h0D,6'h0D,0,1, 1,0,0,0);
    add(6'h0D,6'h0D,0,1, 10,0,0,0); add(6'h0D,6'h0D,0,1, 11,0,0,0);
    // ori with opcode_i changed after DECODE: latched opcode must govern
    add(6'h0D,6'h0D,0,1, 0,1,1,0); add(6'h0D,6'h0D,0,1, 1,0,0,0);
    add(6'h08,6'h0D,0,1, 10,0,0,0); add(6'h08,6'h0D,0,1, 11,0,0,0);
    // illegal opcode
    add(6'h3F,6'h3F,0,1, 0,1,1,0); add(6'h3F,6'h3F,0,1, 1,0,0,1);
    // jump opcode
    add(6'h02,6'h02,0,1, 0,1,1,0);
`ifdef MC_CTRL_JUMP_EN
    add(6'h02,6'h02,0,1, 1,0,0,0); add(6'h02,6'h02,0,1, 9,1,0,0);
`else
    add(6'h02,6'h02,0,1, 1,0,0,1);
`endif
    // waited fetch: 3 low cycles then ready on the boundary cycle
    add(6'h00,6'h00,0,0, 0,0,0,0); add(6'h00,6'h00,0,0, 0,0,0,0);
    add(6'h00,6'h00,0,0, 0,0,0,0); add(6'h00,6'h00,0,1, 0,1,1,0);
    add(6'h00,6'h00,0,1, 1,0,0,0); add(6'h00,6'h00,0,1, 6,0,0,0); add(6'h00,6'h00,0,1, 7,0,0,0);
    // fetch timeout then retry
    add(6'h00,6'h00,0,0, 0,0,0,0); add(6'h00,6'h00,0,0, 0,0,0,0);
    add(6'h00,6'h00,0,0, 0,0,0,0); add(6'h00,6'h00,0,0, 0,0,0,1);
    add(6'h00,6'h00,0,1, 0,1,1,0); add(6'h00,6'h00,0,1, 1,0,0,0);
    add(6'h00,6'h00,0,1, 6,0,0,0); add(6'h00,6'h00,0,1, 7,0,0,0);
    // sw timeout
    add(6'h2B,6'h2B,0,1, 0,1,1,0); add(6'h2B,6'h2B,0,1, 1,0,0,0); add(6'h2B,6'h2B,0,1, 2,0,0,0);
    add(6'h2B,6'h2B,0,0, 5,0,0,0); add(6'h2B,6'h2B,0,0, 5,0,0,0);
    add(6'h2B,6'h2B,0,0, 5,0,0,0); add(6'h2B,6'h2B,0,0, 5,0,0,1);
    // lw with ready arriving on the boundary cycle
    add(6'h23,6'h23,0,1, 0,1,1,0); add(6'h23,6'h23,0,1, 1,0,0,0); add(6'h23,6'h23,0,1, 2,0,0,0);
    add(6'h23,6'h23,0,0, 3,0,0,0); add(6'h23,6'h23,0,0, 3,0,0,0);
    add(6'h23,6'h23,0,0, 3,0,0,0); add(6'h23,6'h23,0,1, 3,0,0,0);
    add(6'h23,6'h23,0,1, 4,0,0,0);
    // R-type start for the mid-instruction reset
    add(6'h00,6'h00,0,1, 0,1,1,0); add(6'h00,6'h00,0,1, 1,0,0,0); add(6'h00,6'h00,0,1, 6,0,0,0);

    @(negedge clk_i);
    rst_i = 1'b1; mem_ready_i = 1'b0;

    for (int i = 0; i < vecs.size(); i++) step(vecs[i], i);

    // asynchronous reset in ALU_WB, with ready high to show it is masked
    @(posedge clk_i);
    #3;
    rst_i = 1'b0; mem_ready_i = 1'b1;
    #1;
    compare("rst_async", actual(), expect_out(4'd0, 6'h00, 1'b0, 1'b0, 1'b0));
    @(posedge clk_i);
    #2;
    compare("rst_hold", actual(), expect_out(4'd0, 6'h00, 1'b0, 1'b0, 1'b0));
    @(negedge clk_i);
    rst_i = 1'b1; mem_ready_i = 1'b0;
    begin
      vec_t v;
      v.opc = 6'h00; v.ctx = 6'h00; v.zero = 0; v.rdy = 1;
      v.st = 4'd0; v.pcen = 1; v.irw = 1; v.err = 0;
      step(v, 1000);
      v.st = 4'd1; v.pcen = 0; v.irw = 0;
      step(v, 1001);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mc_ctrl.md
# mc_ctrl

Multi-cycle control sequencer for the MIPS-subset datapath. It steps each instruction through fetch, decode, execute, memory and write-back states, and drives every datapath select and enable signal: PC, IR, register file, ALU operand muxes and the shared instruction/data memory port. It sits beside the datapath and replaces the single-cycle decoder. Memory accesses use a ready handshake with a timeout.

## Interface
- `WAIT_MAX`, default 15: maximum cycles a memory access waits for `mem_ready_i` before aborting. Legal range 1..255.

- `clk_i` in 1: clock, rising edge.
- `rst_i` in 1: asynchronous reset, active-low.
- `opcode_i` in 6: `IR[31:26]`. Sampled only in DECODE.
- `zero_i` in 1: ALU zero flag. Used in BRANCH.
- `mem_ready_i` in 1: memory completes the current access this cycle.
- `pc_en_o` out 1: PC register load enable.
- `iord_o` out 1: memory address select. 0 = PC, 1 = ALUOut.
- `mem_read_o` out 1: memory read request.
- `mem_write_o` out 1: memory write request.
- `ir_write_o` out 1: IR load enable.
- `memtoreg_o` out 1: write-back data select. 0 = ALUOut, 1 = MDR.
- `reg_dst_o` out 1: write register select. 0 = rt, 1 = rd.
- `reg_write_o` out 1: register file write enable.
- `alu_src_a_o` out 1: ALU operand A select. 0 = PC, 1 = A register.
- `alu_src_b_o` out 2: ALU operand B select. 00 = B, 01 = constant 4, 10 = extended immediate, 11 = extended immediate << 2.
- `alu_op_o` out 3: ALU operation. 000 add, 001 sub, 010 R-type (use funct), 011 slt, 100 or.
- `zext_o` out 1: immediate is zero-extended (ori). 0 = sign-extend.
- `pc_src_o` out 2: next-PC select. 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `state_o` out 4: current state, for debug.
- `err_o` out 1: one-cycle pulse on illegal opcode or memory timeout.

## Operation
State encodings:
- FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5, EXEC_R=6, ALU_WB=7, BRANCH=8, JUMP=9, EXEC_I=10, I_WB=11.
- Encodings 12-15 are unreachable. If one is entered, the next state is FETCH.

Per-state outputs (every output not listed is 0):
- **FETCH:** `mem_read_o`=1, `iord_o`=0, `alu_src_a_o`=0, `alu_src_b_o`=01, `alu_op_o`=000, `pc_src_o`=00.
  - `ir_write_o` and `pc_en_o` are 1 only in the cycle where `mem_ready_i`=1.
  - Next state is DECODE on ready; otherwise stay in FETCH.
- **DECODE:** `alu_src_a_o`=0, `alu_src_b_o`=11, `alu_op_o`=000. This precomputes the branch target into ALUOut.
  - Next state by opcode: 0x00 → EXEC_R; 0x23 or 0x2B → MEM_ADDR; 0x04 or 0x05 → BRANCH; 0x08, 0x0A or 0x0D → EXEC_I; 0x02 → JUMP (see Configuration).
  - Any other opcode → FETCH with `err_o` pulsed. The PC has already advanced, so the instruction is skipped.
- **MEM_ADDR:** `alu_src_a_o`=1, `alu_src_b_o`=10, add. Next state is MEM_READ for lw, MEM_WRITE for sw.
- **MEM_READ:** `mem_read_o`=1, `iord_o`=1. Next state is MEM_WB on ready.
- **MEM_WB:** `reg_write_o`=1, `memtoreg_o`=1, `reg_dst_o`=0. Next state is FETCH.
- **MEM_WRITE:** `mem_write_o`=1, `iord_o`=1. Next state is FETCH on ready.
- **EXEC_R:** `alu_src_a_o`=1, `alu_src_b_o`=00, `alu_op_o`=010. Next state is ALU_WB.
- **ALU_WB:** `reg_write_o`=1, `reg_dst_o`=1. Next state is FETCH.
- **EXEC_I:** `alu_src_a_o`=1, `alu_src_b_o`=10.
  - `alu_op_o` is 000 for addi, 011 for slti, 100 for ori.
  - `zext_o`=1 for ori only.
  - Next state is I_WB.
- **I_WB:** `reg_write_o`=1, `reg_dst_o`=0. Next state is FETCH.
- **BRANCH:** `alu_src_a_o`=1, `alu_src_b_o`=00, `alu_op_o`=001, `pc_src_o`=01.
  - `pc_en_o` = `zero_i` for beq (0x04) and `!zero_i` for bne (0x05).
  - Next state is FETCH.
- **JUMP:** `pc_src_o`=10, `pc_en_o`=1. Next state is FETCH.

Latched opcode:
- The opcode is latched into an internal register in DECODE.
- All later states use the latched value, not `opcode_i`.

## Timing
Reset:
- `rst_i`=0 asynchronously forces state FETCH, the wait counter to 0 and the latched opcode to 0.
- While reset is held, all outputs are at their FETCH values with `mem_ready_i` treated as 0. That means `mem_read_o`=1, `alu_src_b_o`=01 and every other output 0.
- Reset asserted mid-instruction abandons the instruction with no further writes.

Cycles per instruction with zero wait states: R-type 4, addi/slti/ori 4, lw 5, sw 4, beq/bne 3, j 3.

Memory handshake:
- Applies in the request states FETCH, MEM_READ and MEM_WRITE.
- The request is held constant until the cycle in which `mem_ready_i`=1; the access completes in that cycle.
- An 8-bit wait counter increments each cycle that ready is low and clears on state exit.
- When the counter reaches `WAIT_MAX` with ready still low:
  - the next state is FETCH and `err_o` pulses for one cycle;
  - no PC, IR, register or memory write occurs;
  - a timed-out FETCH retries the same PC.
- Ready arriving in the same cycle the counter reaches `WAIT_MAX` wins: the access completes and there is no error.
- `mem_ready_i` is ignored in non-request states.

## Configuration
- `MC_CTRL_JUMP_EN` defined: opcode 0x02 is decoded to JUMP.
- `MC_CTRL_JUMP_EN` undefined: the JUMP state is not compiled. Opcode 0x02 is illegal and takes the DECODE → FETCH path with `err_o` pulsed. All other behaviour is identical.

## Test plan
- **Reset.** Drive `rst_i`=0 asynchronously mid-cycle → `state_o`=0 immediately; `mem_read_o`=1; `pc_en_o`, `reg_write_o` and `err_o` are 0.
- **R-type then lw, zero wait.** `mem_ready_i` tied to 1, opcode 0x00 then 0x23 → `state_o` sequence 0,1,6,7,0,1,2,3,4,0. `reg_write_o` is high in cycles 4 and 9 only.
- **beq / bne.** beq with `zero_i`=1 → `pc_en_o`=1 and `pc_src_o`=01 in state 8. bne with `zero_i`=1 → `pc_en_o`=0 in state 8.
- **Waited fetch.** `mem_ready_i` low for 3 FETCH cycles, then high → `ir_write_o` and `pc_en_o` pulse once, on the 4th cycle only.
- **Timeout.** `WAIT_MAX`=4 and `mem_ready_i` held low in MEM_WRITE → after 4 cycles `err_o` pulses, state goes to 0, and `mem_write_o` never completes.
- **Illegal and jump opcodes.** Opcode 0x3F → `err_o` pulse in DECODE, next state 0. Opcode 0x02 → state 9 when `MC_CTRL_JUMP_EN` is defined; an `err_o` pulse when it is undefined.
